// File: rtl/sha256_round_ctrl_if.sv
// Block-request, scheduler and datapath-control handshake between the SHA-256
// round sequencer and its neighbours.
interface sha256_round_ctrl_if;
  logic        blk_valid;
  logic        blk_first;
  logic        blk_last;
  logic        blk_ready;
  logic        ws_valid;
  logic        init;
  logic        init_iv;
  logic        round_en;
  logic [5:0]  round;
  logic [31:0] k;
  logic        fold;
  logic        digest_valid;
  logic        digest_ack;
  logic        busy;

  modport master (
    input  blk_valid, blk_first, blk_last, ws_valid, digest_ack,
    output blk_ready, init, init_iv, round_en, round, k, fold, digest_valid, busy
  );

  modport slave (
    output blk_valid, blk_first, blk_last, ws_valid, digest_ack,
    input  blk_ready, init, init_iv, round_en, round, k, fold, digest_valid, busy
  );
endinterface

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: init pulse, 64 scheduler-paced rounds with
// K constants, fold pulse and a digest-valid handshake after the last block.
module sha256_round_ctrl (
  input  logic                      clk,
  input  logic                      rst_n,
  sha256_round_ctrl_if.master       bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  state_t     state_q;
  logic [5:0] round_q;
  logic       first_q;
  logic       last_q;
  logic       blk_ready_q;
  logic       busy_q;
  logic       init_q;
  logic       init_iv_q;
  logic       fold_q;
  logic       digest_valid_q;

  // Output flags are registered alongside the state so each one reflects the
  // state being entered; the round counter only ever advances or wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      round_q        <= 6'd0;
      first_q        <= 1'b0;
      last_q         <= 1'b0;
      blk_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      init_q         <= 1'b0;
      init_iv_q      <= 1'b0;
      fold_q         <= 1'b0;
      digest_valid_q <= 1'b0;
    end else begin
      init_q    <= 1'b0;
      init_iv_q <= 1'b0;
      fold_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.blk_valid) begin
            first_q     <= bus.blk_first;
            last_q      <= bus.blk_last;
            init_q      <= 1'b1;
            init_iv_q   <= bus.blk_first;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_INIT;
          end
        end
        ST_INIT: begin
          state_q <= ST_ROUND;
        end
        ST_ROUND: begin
          if (bus.ws_valid) begin
            round_q <= round_q + 6'd1;
            if (round_q == 6'd63) begin
              fold_q  <= 1'b1;
              state_q <= ST_FOLD;
            end
          end
        end
        ST_FOLD: begin
          if (last_q) begin
            digest_valid_q <= 1'b1;
            state_q        <= ST_DONE;
          end else begin
            blk_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          // A request seen together with the ack waits for the next IDLE cycle.
          if (bus.digest_ack) begin
            digest_valid_q <= 1'b0;
            blk_ready_q    <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.blk_ready    = blk_ready_q;
  assign bus.busy         = busy_q;
  assign bus.init         = init_q;
  assign bus.init_iv      = init_iv_q;
  assign bus.fold         = fold_q;
  assign bus.digest_valid = digest_valid_q;
  assign bus.round        = round_q;
  assign bus.round_en     = (state_q == ST_ROUND) && bus.ws_valid;
  assign bus.k            = K_ROM[round_q];

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed bench for sha256_round_ctrl: reset, single/two-block messages,
// scheduler stalls, busy-time requests and stray acknowledges.
module tb_sha256_round_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   fold_seen;
  int   fold_base;

  sha256_round_ctrl_if bus ();

  sha256_round_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial fold_seen = 0;
  always @(negedge clk) if (bus.fold === 1'b1) fold_seen++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_blk_ready"}, 32'(bus.blk_ready), 32'd1);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_init"}, 32'(bus.init), 32'd0);
    check_val({tag, "_init_iv"}, 32'(bus.init_iv), 32'd0);
    check_val({tag, "_round_en"}, 32'(bus.round_en), 32'd0);
    check_val({tag, "_fold"}, 32'(bus.fold), 32'd0);
    check_val({tag, "_digest_valid"}, 32'(bus.digest_valid), 32'd0);
    check_val({tag, "_round"}, 32'(bus.round), 32'd0);
    check_val({tag, "_k"}, bus.k, 32'h428a2f98);
  endtask

  // Called in an IDLE cycle, just after the input-drive point.
  // Stall pattern (ws_valid low in cycles 7,8,9,68) parks round 5 for 3
  // cycles and round 63 for 1, moving the fold from cycle 66 to 70.
  task automatic run_block(input bit first, input bit last, input bit stall, input bit stray);
    int exp_fold;
    int exp_round;
    int en_cnt;
    int trace_err;
    bit ws;
    exp_fold  = stall ? 70 : 66;
    exp_round = 0;
    en_cnt    = 0;
    trace_err = 0;
    bus.blk_valid = 1'b1;
    bus.blk_first = first;
    bus.blk_last  = last;
    bus.ws_valid  = 1'b1;
    #1;
    check_val("accept_ready", 32'(bus.blk_ready), 32'd1);
    tick();
    bus.blk_valid = 1'b0;
    bus.blk_first = 1'b0;
    bus.blk_last  = 1'b0;
    #1;
    check_val("init_pulse", 32'(bus.init), 32'd1);
    check_val("init_iv", 32'(bus.init_iv), 32'(first));
    check_val("init_round", 32'(bus.round), 32'd0);
    check_val("init_k", bus.k, 32'h428a2f98);
    check_val("init_round_en", 32'(bus.round_en), 32'd0);
    check_val("init_busy", 32'(bus.busy), 32'd1);
    for (int c = 2; c < exp_fold; c++) begin
      tick();
      ws = !(stall && (c == 7 || c == 8 || c == 9 || c == 68));
      bus.ws_valid   = ws;
      bus.digest_ack = stray && (c == 20);
      bus.blk_valid  = stray && (c == 30);
      #1;
      if (int'(bus.round) != exp_round) trace_err++;
      if (bus.round_en !== ws) trace_err++;
      if (bus.init !== 1'b0 || bus.fold !== 1'b0 || bus.digest_valid !== 1'b0) trace_err++;
      if (stall && c == 8) begin
        check_val("stall_hold_r5", 32'(bus.round), 32'd5);
        check_val("stall_round_en_r5", 32'(bus.round_en), 32'd0);
      end
      if (stall && c == 68) begin
        check_val("stall_hold_r63", 32'(bus.round), 32'd63);
        check_val("stall_round_en_r63", 32'(bus.round_en), 32'd0);
      end
      if (ws && exp_round == 1)  check_val("k_round1", bus.k, 32'h71374491);
      if (ws && exp_round == 63) check_val("k_round63", bus.k, 32'hc67178f2);
      if (ws) begin
        en_cnt++;
        exp_round++;
      end
    end
    tick();
    bus.digest_ack = 1'b0;
    bus.blk_valid  = 1'b0;
    bus.ws_valid   = 1'b1;
    #1;
    check_val("fold_pulse", 32'(bus.fold), 32'd1);
    check_val("fold_round_wrap", 32'(bus.round), 32'd0);
    check_val("fold_round_en", 32'(bus.round_en), 32'd0);
    check_val("fold_busy", 32'(bus.busy), 32'd1);
    check_val("round_en_count", 32'(en_cnt), 32'd64);
    check_val("round_trace_errs", 32'(trace_err), 32'd0);
    tick();
    #1;
    check_val("post_fold_pulse", 32'(bus.fold), 32'd0);
    check_val("post_fold_dv", 32'(bus.digest_valid), 32'(last));
    check_val("post_fold_ready", 32'(bus.blk_ready), 32'(!last));
    check_val("post_fold_busy", 32'(bus.busy), 32'(last));
    $display("block first=%0d last=%0d stall=%0d stray=%0d: fold at cycle %0d, %0d rounds",
             first, last, stall, stray, exp_fold, en_cnt);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.blk_valid  = 1'b0;
    bus.blk_first  = 1'b0;
    bus.blk_last   = 1'b0;
    bus.ws_valid   = 1'b1;
    bus.digest_ack = 1'b0;
    rst_n = 1'b0;
    #12;
    check_reset("reset");
    tick();
    rst_n = 1'b1;
    tick();
    check_reset("idle");

    // Single block, no stalls; request in DONE is ignored, then ack.
    run_block(1'b1, 1'b1, 1'b0, 1'b0);
    bus.blk_valid = 1'b1;
    tick();
    bus.blk_valid = 1'b0;
    #1;
    check_val("done_req_ignored_dv", 32'(bus.digest_valid), 32'd1);
    check_val("done_req_no_init", 32'(bus.init), 32'd0);
    bus.digest_ack = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
    #1;
    check_val("ack_dv_clear", 32'(bus.digest_valid), 32'd0);
    check_val("ack_ready", 32'(bus.blk_ready), 32'd1);
    check_val("ack_busy", 32'(bus.busy), 32'd0);
    $display("digest acknowledged");

    // Stray acknowledge in IDLE.
    bus.digest_ack = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
    #1;
    check_val("stray_ack_ready", 32'(bus.blk_ready), 32'd1);
    check_val("stray_ack_busy", 32'(bus.busy), 32'd0);

    // Stalled block with stray ack and request during ROUND.
    run_block(1'b1, 1'b1, 1'b1, 1'b1);

    // Ack and new request together in DONE: accepted one cycle later.
    bus.digest_ack = 1'b1;
    bus.blk_valid  = 1'b1;
    bus.blk_first  = 1'b1;
    bus.blk_last   = 1'b0;
    #1;
    check_val("done_ack_req_ready", 32'(bus.blk_ready), 32'd0);
    tick();
    bus.digest_ack = 1'b0;
    #1;
    check_val("ack_req_idle_ready", 32'(bus.blk_ready), 32'd1);
    check_val("ack_req_no_init", 32'(bus.init), 32'd0);
    tick();
    bus.blk_valid = 1'b0;
    #1;
    check_val("held_req_init", 32'(bus.init), 32'd1);
    check_val("held_req_init_iv", 32'(bus.init_iv), 32'd1);
    $display("held request accepted after ack");

    // Abort mid-block with an asynchronous reset at round 17.
    for (int i = 0; i < 18; i++) tick();
    #1;
    check_val("pre_reset_round", 32'(bus.round), 32'd17);
    fold_base = fold_seen;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check_reset("post_abort");
    check_val("abort_no_fold", 32'(fold_seen - fold_base), 32'd0);
    $display("reset at round 17 discarded block");

    // Two-block message, back to back.
    fold_base = fold_seen;
    run_block(1'b1, 1'b0, 1'b0, 1'b0);
    run_block(1'b0, 1'b1, 1'b0, 1'b0);
    bus.digest_ack = 1'b1;
    tick();
    bus.digest_ack = 1'b0;
    #1;
    check_val("two_blk_fold_count", 32'(fold_seen - fold_base), 32'd2);
    check_val("two_blk_ack_ready", 32'(bus.blk_ready), 32'd1);
    $display("two-block message complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sha256_round_ctrl.md
# sha256_round_ctrl

Sequencer for the SHA-256 compression datapath. It accepts one 512-bit block request at a time and pulses the datapath's working-variable load. It then steps the 64 rounds, supplying the round index and the matching K constant, and stalls whenever the message scheduler has no W word ready. When the rounds finish it pulses the fold of the working variables into the hash state and, after the last block of a message, holds a digest-valid handshake until the consumer acknowledges it.

## Interface
Parameters: none.

- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- blk_valid  in  1  block request; the W scheduler is loaded for this block
- blk_first  in  1  block is the first of its message (sampled with blk_valid)
- blk_last  in  1  block is the last of its message (sampled with blk_valid)
- blk_ready  out  1  controller can accept a block (high in IDLE only)
- ws_valid  in  1  message scheduler presents a valid W for the current round
- init  out  1  one-cycle pulse: datapath loads a..h
- init_iv  out  1  qualifies init: 1 = load the FIPS 180-4 IV, 0 = load from the current hash state
- round_en  out  1  datapath executes one round this cycle (= ROUND state & ws_valid)
- round  out  6  current round index 0..63
- k  out  32  K[round], combinational from the round register
- fold  out  1  one-cycle pulse: hash state += a..h
- digest_valid  out  1  final digest is available on the datapath HASH bus
- digest_ack  in  1  consumer takes the digest
- busy  out  1  state != IDLE

## Operation
The controller is a five-state FSM: IDLE, INIT, ROUND, FOLD, DONE.

**IDLE**
- blk_ready=1.
- On blk_valid: latch first_q=blk_first and last_q=blk_last, then go to INIT.

**INIT** (exactly 1 cycle)
- init=1, init_iv=first_q, round=0.
- Go to ROUND.

**ROUND**
- round_en=ws_valid.
- When round_en=1, round increments.
- When round_en=1 and round=63, go to FOLD; round wraps to 0 on that edge.
- When ws_valid=0, the FSM holds, round holds and round_en=0; the stall is unbounded.

**FOLD** (exactly 1 cycle)
- fold=1.
- If last_q=1, go to DONE; otherwise go to IDLE.

**DONE**
- digest_valid=1.
- digest_ack while digest_valid=1 returns to IDLE.
- digest_ack in any other state is ignored.

**K ROM**
- 64 entries of 32 bits, holding the FIPS 180-4 constants.
- k is always driven, so it equals K[0]=32'h428a2f98 whenever round=0.

**General rules**
- blk_valid, blk_first and blk_last are ignored outside IDLE. A request arriving while busy is not queued; the requester holds blk_valid until blk_ready.
- init_iv is meaningful only while init=1, and is 0 otherwise.
- The round counter is 6 bits with natural wrap; it is never loaded except by reset or the 63→0 wrap.

## Timing
**Reset values** (asserted asynchronously while rst_n=0):
- state=IDLE, round=0, first_q=0, last_q=0.
- blk_ready=1, busy=0.
- init=0, init_iv=0, round_en=0, fold=0, digest_valid=0.
- k=32'h428a2f98.

**Outputs**
- All outputs are decoded from registered state.
- Only round_en and k have a combinational path: round_en from ws_valid, k from round.

**Latency with no stall**, with accept at edge 0:
- INIT during cycle 1.
- Rounds 0..63 during cycles 2..65.
- FOLD during cycle 66.
- digest_valid from cycle 67 (last block), or blk_ready from cycle 67 (non-last block).
- Total: 67 cycles from accept to next blk_ready. Each ws_valid stall cycle adds 1.

**Back-to-back blocks**
- The next block can be accepted in the first IDLE cycle. There is no IDLE bypass.

**Reset mid-operation**
- Immediate return to IDLE with all outputs at reset values.
- A partially processed block is discarded, and no fold occurs.

**Simultaneous events**
- digest_ack together with a new blk_valid in DONE: the ack is honoured and the block is not accepted. It is accepted in the following IDLE cycle.

## Test plan
1. **Reset values:** drive rst_n=0 mid-ROUND at round=17 → all outputs take their reset values asynchronously, k=32'h428a2f98, blk_ready=1, no fold pulse.
2. **Single block, no stalls:** blk_valid with blk_first=1, blk_last=1, ws_valid tied 1.
   - init with init_iv=1 one cycle after accept.
   - round_en high for exactly 64 consecutive cycles; k=32'h71374491 at round 1 and k=32'hc67178f2 at round 63.
   - fold pulse at cycle 66, digest_valid at cycle 67.
   - digest_ack → IDLE and blk_ready=1 on the next cycle.
3. **Scheduler stalls:** ws_valid low for 3 cycles at round 5 and for 1 cycle at round 63 → round holds at 5 and at 63, round_en=0 during the stalls, and the fold pulse moves to cycle 70.
4. **Two-block message:** block A with first=1, last=0, then block B with first=0, last=1.
   - A: init_iv=1, fold, then return to IDLE with digest_valid=0.
   - B: init_iv=0, then digest_valid after B's fold only.
   - Exactly 2 fold pulses in total.
5. **Requests while busy:** pulse blk_valid during ROUND and during DONE → ignored, with no second init. In DONE, assert digest_ack and blk_valid together → returns to IDLE and accepts the held request one cycle later.
6. **Stray acknowledge:** digest_ack asserted in IDLE and in ROUND → no state change, round sequence unaffected.
